// File: rtl/core_pkg.sv
// Shared encodings for the RV32I multicycle sequencer: opcodes, datapath
// control codes, FSM states and trap causes.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctl_e;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;

  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_e;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM_TO = 2'b10,
    CAUSE_DMEM_TO = 2'b11
  } trap_cause_e;

  // funct7[5] selects SUB only for register-register ops; for shifts it selects SRA.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5,
                                        input logic is_rtype);
    case (f3)
      3'b000:  return (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/core_decoder.sv
// Combinational instruction decoder: IR to datapath controls and
// instruction-class flags used by the sequencer.
module core_decoder
  import core_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic        alu_src_o,
  output logic [1:0]  imm_src_o,
  output logic [1:0]  result_src_o,
  output logic [3:0]  alu_control_o,
  output logic        reg_write_dec_o,
  output logic        is_branch_o,
  output logic        is_jal_o,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_ir_bits;

  assign opcode = ir_i[6:0];
  assign funct3 = ir_i[14:12];
  assign f7b5   = ir_i[30];
  assign unused_ir_bits = ^{ir_i[31], ir_i[29:15], ir_i[11:7]};

  always_comb begin
    alu_src_o       = 1'b0;
    imm_src_o       = IMM_I;
    result_src_o    = RES_ALU;
    alu_control_o   = ALU_ADD;
    reg_write_dec_o = 1'b0;
    is_branch_o     = 1'b0;
    is_jal_o        = 1'b0;
    is_load_o       = 1'b0;
    is_store_o      = 1'b0;
    illegal_o       = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write_dec_o = 1'b1;
        alu_control_o   = alu_op(funct3, f7b5, 1'b1);
      end
      OP_IALU: begin
        alu_src_o       = 1'b1;
        reg_write_dec_o = 1'b1;
        alu_control_o   = alu_op(funct3, f7b5, 1'b0);
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          is_branch_o   = 1'b1;
          imm_src_o     = IMM_B;
          alu_control_o = ALU_SUB;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_JAL: begin
        is_jal_o        = 1'b1;
        imm_src_o       = IMM_J;
        result_src_o    = RES_PC4;
        reg_write_dec_o = 1'b1;
      end
      OP_LOAD: begin
        if (funct3 == F3_WORD) begin
          is_load_o       = 1'b1;
          alu_src_o       = 1'b1;
          result_src_o    = RES_MEM;
          reg_write_dec_o = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == F3_WORD) begin
          is_store_o = 1'b1;
          alu_src_o  = 1'b1;
          imm_src_o  = IMM_S;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multicycle RV32I sequencer: fetch handshake, IR, one-cycle commit strobes,
// data-memory sequencing, watchdog with sticky trap, and retired-instruction count.
module core_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instr,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic             Zero,
  output logic             PCEn,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       ResultSrc,
  output logic [3:0]       ALUControl,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e           state_q;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] instret_q;
  logic [1:0]       cause_q;
  logic [WD_W-1:0]  wd_q;
  logic [WD_W-1:0]  wd_d;
  logic             timeout_hit;

  logic reg_write_dec, is_branch, is_jal, is_load, is_store, illegal;
  logic exec_commit, mem_commit, commit, branch_taken;

  core_decoder u_dec (
    .ir_i            (ir_q),
    .alu_src_o       (ALUSrc),
    .imm_src_o       (ImmSrc),
    .result_src_o    (ResultSrc),
    .alu_control_o   (ALUControl),
    .reg_write_dec_o (reg_write_dec),
    .is_branch_o     (is_branch),
    .is_jal_o        (is_jal),
    .is_load_o       (is_load),
    .is_store_o      (is_store),
    .illegal_o       (illegal)
  );

  assign wd_d        = wd_q + WD_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (wd_d == WD_W'(TIMEOUT));

  assign exec_commit  = (state_q == S_EXEC) && !illegal && !is_load && !is_store;
  assign mem_commit   = (state_q == S_MEM) && dmem_ready;
  assign commit       = exec_commit || mem_commit;
  // funct3[0] separates bne from beq
  assign branch_taken = is_branch && (ir_q[12] ? !Zero : Zero);

  // imem_req is gated by reset so it drops immediately when reset asserts.
  assign imem_req   = reset && (state_q == S_FETCH);
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_req && is_store;
  assign PCEn       = commit;
  assign RegWrite   = commit && reg_write_dec;
  assign PCSrc      = (state_q == S_EXEC) && (is_jal || branch_taken);
  assign Instr      = ir_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      ir_q      <= NOP_INSTR;
      instret_q <= '0;
      cause_q   <= CAUSE_NONE;
      wd_q      <= '0;
    end else begin
      if (commit) instret_q <= instret_q + CNT_W'(1);
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            ir_q    <= imem_rdata;
            wd_q    <= '0;
            state_q <= S_EXEC;
          end else if (timeout_hit) begin
            state_q <= S_TRAP;
            cause_q <= CAUSE_IMEM_TO;
          end else begin
            wd_q <= wd_d;
          end
        end
        S_EXEC: begin
          wd_q <= '0;
          if (illegal) begin
            state_q <= S_TRAP;
            cause_q <= CAUSE_ILLEGAL;
          end else if (is_load || is_store) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            wd_q    <= '0;
            state_q <= S_FETCH;
          end else if (timeout_hit) begin
            state_q <= S_TRAP;
            cause_q <= CAUSE_DMEM_TO;
          end else begin
            wd_q <= wd_d;
          end
        end
        S_TRAP: state_q <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a per-cycle reference model checks every
// output, and literal expectations at key points pin the model itself.
module tb_core_sequencer;

  localparam int TIMEOUT = 4;

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] SUB  = 32'h4020_81B3;
  localparam logic [31:0] BEQ  = 32'h0020_8463;
  localparam logic [31:0] LW   = 32'h0040_A283;
  localparam logic [31:0] SW   = 32'h0050_A223;
  localparam logic [31:0] LUI  = 32'h0000_00B7;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  // ALU code per funct3, one nibble each: ADD SLL SLT SLTU XOR SRL OR AND
  localparam logic [31:0] F3_ALU_PACK = 32'h2374_9560;

  localparam logic [2:0] K_R = 0, K_I = 1, K_BR = 2, K_JAL = 3, K_LD = 4, K_ST = 5, K_ILL = 6;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] imm;
    logic [1:0] res;
    logic [3:0] alu;
    logic [2:0] kind;
  } dec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dmem_ready = 1'b0;
  logic        Zero = 1'b0;
  logic        imem_req, dmem_req, dmem_we, PCEn, PCSrc, RegWrite, ALUSrc, trap;
  logic [31:0] Instr, instret;
  logic [1:0]  ImmSrc, ResultSrc, trap_cause;
  logic [3:0]  ALUControl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .Instr(Instr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .Zero(Zero), .PCEn(PCEn), .PCSrc(PCSrc), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    d  = '{alu_src: 1'b0, imm: 2'd0, res: 2'd0, alu: 4'd0, kind: K_ILL};
    if (op == 7'h33 || op == 7'h13) begin
      d.kind    = (op == 7'h33) ? K_R : K_I;
      d.alu_src = (op == 7'h13);
      d.alu     = F3_ALU_PACK[f3*4 +: 4];
      if (f3 == 3'd5 && ins[30]) d.alu = 4'd8;
      if (op == 7'h33 && f3 == 3'd0 && ins[30]) d.alu = 4'd1;
    end else if (op == 7'h63 && f3 < 3'd2) begin
      d.kind = K_BR; d.imm = 2'd2; d.alu = 4'd1;
    end else if (op == 7'h6F) begin
      d.kind = K_JAL; d.imm = 2'd3; d.res = 2'd2;
    end else if (op == 7'h03 && f3 == 3'd2) begin
      d.kind = K_LD; d.alu_src = 1'b1; d.res = 2'd1;
    end else if (op == 7'h23 && f3 == 3'd2) begin
      d.kind = K_ST; d.alu_src = 1'b1; d.imm = 2'd1;
    end
    return d;
  endfunction

  // Reference model: where 0=fetching, 1=executing, 2=memory access, 3=trapped.
  int          m_where = 0;
  int          m_wait = 0;
  logic [31:0] m_ir = NOP;
  logic [31:0] m_instret = '0;
  logic [1:0]  m_cause = '0;
  dec_t        md;
  logic        m_commit, m_writes, m_pcsrc;

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      m_where = 0; m_wait = 0; m_ir = NOP; m_instret = '0; m_cause = '0;
    end
    md       = decode(m_ir);
    m_commit = reset && ((m_where == 1 && md.kind <= K_JAL) || (m_where == 2 && dmem_ready));
    m_writes = (md.kind == K_R || md.kind == K_I || md.kind == K_JAL || md.kind == K_LD);
    m_pcsrc  = reset && m_where == 1 &&
               (md.kind == K_JAL || (md.kind == K_BR && (m_ir[14:12] == 3'd0 ? Zero : !Zero)));
    chk("imem_req", imem_req, reset && m_where == 0);
    chk("dmem_req", dmem_req, m_where == 2);
    chk("dmem_we", dmem_we, m_where == 2 && md.kind == K_ST);
    chk("PCEn", PCEn, m_commit);
    chk("RegWrite", RegWrite, m_commit && m_writes);
    chk("PCSrc", PCSrc, m_pcsrc);
    chk("ALUSrc", ALUSrc, md.alu_src);
    chk("ImmSrc", ImmSrc, md.imm);
    chk("ResultSrc", ResultSrc, md.res);
    chk("ALUControl", ALUControl, md.alu);
    chk("Instr", Instr, m_ir);
    chk("trap", trap, m_where == 3);
    chk("trap_cause", trap_cause, m_cause);
    chk("instret", instret, m_instret);
    if (reset) begin
      if (m_commit) m_instret = m_instret + 1;
      case (m_where)
        0: if (imem_ready) begin
             m_ir = imem_rdata; m_wait = 0; m_where = 1;
           end else begin
             m_wait++;
             if (TIMEOUT != 0 && m_wait == TIMEOUT) begin m_where = 3; m_cause = 2'b10; end
           end
        1: if (md.kind <= K_JAL) m_where = 0;
           else if (md.kind == K_ILL) begin m_where = 3; m_cause = 2'b01; end
           else begin m_where = 2; m_wait = 0; end
        2: if (dmem_ready) begin
             m_where = 0; m_wait = 0;
           end else begin
             m_wait++;
             if (TIMEOUT != 0 && m_wait == TIMEOUT) begin m_where = 3; m_cause = 2'b11; end
           end
        default: ;
      endcase
    end
  end

  task automatic cyc(input logic ir, input logic [31:0] rd, input logic dr, input logic z);
    @(negedge clk);
    reset = 1'b1; imem_ready = ir; imem_rdata = rd; dmem_ready = dr; Zero = z;
  endtask

  task automatic rst_hold(input int n);
    repeat (n) begin
      @(negedge clk);
      reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; Zero = 1'b0;
    end
  endtask

  task automatic fetch(input logic [31:0] ins, input int waits);
    repeat (waits) cyc(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cyc(1'b1, ins, 1'b0, 1'b0);
  endtask

  logic [31:0] alu_ins [5] = '{32'h0FF0_C093, 32'h4030_D113, 32'h0020_F1B3, 32'h0020_B233, 32'h0080_00EF};
  logic [3:0]  alu_exp [5] = '{4'd4, 4'd8, 4'd2, 4'd9, 4'd0};

  initial begin
    rst_hold(2);
    #3;
    chk("rst_instret", instret, 0);
    chk("rst_instr", Instr, NOP);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_trap", trap, 0);

    fetch(ADDI, 2);
    cyc(1'b1, SUB, 1'b0, 1'b0);            // stray imem_ready during EXEC
    #3; chk("addi_pcen", PCEn, 1); chk("addi_regwrite", RegWrite, 1); chk("addi_alusrc", ALUSrc, 1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("addi_instret", instret, 1); chk("addi_pcen_once", PCEn, 0);

    fetch(SUB, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("sub_alu", ALUControl, 4'd1); chk("sub_alusrc", ALUSrc, 0);
    fetch(BEQ, 0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    #3; chk("beq_taken", PCSrc, 1); chk("beq_regwrite", RegWrite, 0); chk("beq_pcen", PCEn, 1);
    fetch(BEQ, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("beq_not_taken", PCSrc, 0);

    for (int i = 0; i < 5; i++) begin
      fetch(alu_ins[i], i % 2);
      cyc(1'b0, '0, 1'b0, 1'b0);
      #3; chk("table_alu", ALUControl, alu_exp[i]);
    end

    fetch(ADDI, TIMEOUT - 1);               // ready on the watchdog-limit cycle
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("fetch_ready_wins", PCEn, 1); chk("fetch_ready_no_trap", trap, 0);

    fetch(LW, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);              // stray dmem_ready during EXEC
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("lw_dmem_req", dmem_req, 1); chk("lw_dmem_we", dmem_we, 0); chk("lw_wait_pcen", PCEn, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    #3; chk("lw_regwrite", RegWrite, 1); chk("lw_resultsrc", ResultSrc, 2'b01); chk("lw_pcen", PCEn, 1);

    fetch(SW, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    repeat (TIMEOUT - 1) cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);               // dmem_ready on the watchdog-limit cycle
    #3; chk("sw_we", dmem_we, 1); chk("sw_regwrite", RegWrite, 0); chk("sw_pcen", PCEn, 1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("instret_total", instret, 12); chk("sw_no_trap", trap, 0);

    fetch(LUI, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("lui_pcen", PCEn, 0);
    repeat (3) cyc(1'b1, ADDI, 1'b1, 1'b0);
    #3; chk("lui_trap", trap, 1); chk("lui_cause", trap_cause, 2'b01);
    chk("lui_imem_req", imem_req, 0); chk("lui_instret", instret, 12);

    rst_hold(2);
    repeat (TIMEOUT) cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("imem_to_pending", trap, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("imem_to_trap", trap, 1); chk("imem_to_cause", trap_cause, 2'b10);

    rst_hold(2);
    fetch(LW, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    repeat (TIMEOUT) cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("dmem_to_pending", trap, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("dmem_to_trap", trap, 1); chk("dmem_to_cause", trap_cause, 2'b11);

    rst_hold(1);
    fetch(ADDI, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    fetch(LW, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("mid_mem_req", dmem_req, 1); chk("mid_mem_instret", instret, 1);
    reset = 1'b0;                            // asynchronous, between clock edges
    #1; chk("async_dmem_req", dmem_req, 0); chk("async_instret", instret, 0);
    chk("async_instr", Instr, NOP); chk("async_imem_req", imem_req, 0);
    rst_hold(1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("post_rst_fetch", imem_req, 1); chk("post_rst_instret", instret, 0);
    fetch(ADDI, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3; chk("post_rst_commit", instret, 1);

    @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multicycle controller for the RV32I core datapath. It fetches over a req/ready instruction-memory handshake and latches the instruction into an internal IR. It decodes the instruction into datapath controls and sequences data-memory access. PC and register-file updates (PCEn, RegWrite) happen only on the single commit cycle of each instruction. It also flags illegal instructions and memory timeouts with a sticky trap and counts retired instructions.

Parameters:
TIMEOUT, 255, max cycles to wait for imem_ready/dmem_ready before trapping; 0 disables the watchdog
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
Instr  out  32  IR contents to datapath
dmem_req  out  1  data access request
dmem_we  out  1  store when 1, load when 0
dmem_ready  in  1  data access complete; datapath ReadData valid this cycle
Zero  in  1  ALU zero flag from datapath
PCEn  out  1  PC update enable
PCSrc  out  1  0 = PC+4, 1 = PC target
RegWrite  out  1  register file write enable (commit-gated)
ALUSrc  out  1  0 = rs2, 1 = immediate
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
ResultSrc  out  2  00 ALU, 01 ReadData, 10 PC+4
ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU
trap  out  1  sticky fault flag
trap_cause  out  2  01 illegal instruction, 10 imem timeout, 11 dmem timeout
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (async, while reset=0):
  - state=FETCH, IR=32'h00000013 (NOP), instret=0, trap=0, trap_cause=00, watchdog=0.
  - All req/enable outputs 0.
  - Reset mid-transaction abandons it with no commit.
- Decoded controls (ALUSrc, ImmSrc, ResultSrc, ALUControl) are combinational from IR and valid in every state.
- PCEn, RegWrite, PCSrc, dmem_req and dmem_we are state-gated; they are 0 outside the states listed below.
- FETCH:
  - imem_req=1.
  - On imem_ready: IR<=imem_rdata, watchdog<=0, go to EXEC.
  - Otherwise watchdog++. If watchdog reaches TIMEOUT: TRAP, cause 10.
- EXEC (one cycle), by opcode:
  - R-type 0110011 and I-ALU 0010011: commit. ALUControl from funct3/funct7[5]; SUB only for R-type; SRA when funct7[5]=1. ResultSrc=00.
  - Branch 1100011: funct3 000 (beq) gives PCSrc=Zero; funct3 001 (bne) gives PCSrc=~Zero. ALUControl=SUB, RegWrite=0, commit.
  - JAL 1101111: PCSrc=1, ResultSrc=10, ImmSrc=11, commit.
  - Load 0000011 (funct3 010) and store 0100011 (funct3 010): go to MEM. ALUControl=ADD. Store uses ImmSrc=01.
  - Any other opcode or funct3 (including lui, auipc, jalr, byte/half accesses): TRAP, cause 01, no commit.
- Commit cycle:
  - PCEn=1 and RegWrite=decoded value, for exactly this one cycle.
  - instret++ (wraps modulo 2^CNT_W).
  - Next state FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for store.
  - On dmem_ready: commit. Load gives RegWrite=1, ResultSrc=01. Store gives RegWrite=0.
  - Otherwise watchdog++. If watchdog reaches TIMEOUT: TRAP, cause 11.
- TRAP:
  - Terminal state, exited only by reset.
  - All req/enable outputs 0; IR and instret frozen.
  - trap=1, with trap_cause latched on entry.
- Writes to rd=x0 still assert RegWrite; the register file ignores them.
- imem_ready/dmem_ready seen outside their own request state are ignored.
- If ready arrives in the same cycle the watchdog hits TIMEOUT, ready wins.

Decomposition:
- Package core_pkg holds:
  - opcode constants
  - ALUControl, ImmSrc and ResultSrc encodings
  - state enum (FETCH, EXEC, MEM, TRAP)
  - trap cause codes
- Sub-module core_decoder: purely combinational. IR in; ALUSrc, ImmSrc, ResultSrc, ALUControl, reg_write_dec, is_branch, is_jal, is_load, is_store, illegal out.
- The sequencer FSM, IR, watchdog and instret stay in core_sequencer.

Test Plan:
- addi x1,x0,5 (0x00500093), imem_ready after 2 cycles -> EXEC with ALUSrc=1, ImmSrc=00, ALUControl=0000, RegWrite=1, PCEn=1 for one cycle; instret=1.
- sub x3,x1,x2 (0x402081B3) -> ALUControl=0001, ALUSrc=0. beq (0x00208463) with Zero=1 -> PCSrc=1, RegWrite=0. Same beq with Zero=0 -> PCSrc=0.
- lw x5,4(x1) (0x0040A283), dmem_ready after 3 cycles -> dmem_req=1, dmem_we=0 for 3 cycles. Commit cycle has RegWrite=1, ResultSrc=01, PCEn=1. sw (0x0050A223) -> dmem_we=1, RegWrite=0.
- lui (0x000000B7) -> trap=1, trap_cause=01; no PCEn; imem_req stays 0 until reset.
- TIMEOUT=4, imem_ready held 0 -> trap_cause=10 after 4 cycles. Same setup in MEM with dmem_ready held 0 -> trap_cause=11.
- reset pulled low mid-MEM -> all outputs return to reset values asynchronously. After release: FETCH, instret=0, no commit for the abandoned load.
